// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8-bit UART transmitter, start/8 data (LSB first)/stop framing.
//               Optional parity bit compiled in with macro UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       uart_txd,
   output logic       uart_tx_busy,
   output logic       tx_done
);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_tx: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
   end

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
   } state_t;
`endif

   localparam logic [15:0] C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  data_q, data_d;
   logic        txd_q, txd_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        w_bit_end;
`ifdef UART_PARITY_EN
   logic        w_parity;
`endif

   assign w_bit_end = (baud_q == C_BAUD_LAST);
`ifdef UART_PARITY_EN
   assign w_parity  = (^data_q) ^ (PARITY_ODD != 0);
`endif

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q + 16'd1;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (tx_start) begin
               state_d = S_START;
               data_d  = tx_data;
            end
         end
         S_START: begin
            if (w_bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
                  state_d   = S_PARITY;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            bit_idx_d = 3'd0;
         end
      endcase

      // Every bit boundary, including a state change, restarts the bit timer.
      if (w_bit_end || (state_d != state_q)) baud_d = '0;

      // Line value is derived from the next state so it changes on the same
      // edge as the state register, from a single flop.
      txd_d = 1'b1;
      case (state_d)
         S_IDLE:   txd_d = 1'b1;
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = data_d[bit_idx_d];
`ifdef UART_PARITY_EN
         S_PARITY: txd_d = w_parity;
`endif
         S_STOP:   txd_d = 1'b1;
         default:  txd_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         data_q    <= 8'd0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign uart_txd     = txd_q;
   assign uart_tx_busy = busy_q;
   assign tx_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed, table-driven self-checking bench for uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   localparam int C    = 4;
   localparam int PODD = 0;
`ifdef UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       uart_txd;
   logic       uart_tx_busy;
   logic       tx_done;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx #(
      .CLKS_PER_BIT (C),
      .PARITY_ODD   (PODD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .uart_txd     (uart_txd),
      .uart_tx_busy (uart_tx_busy),
      .tx_done      (tx_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;      // bit k = k-th bit on the wire (8N1 part)
      logic       par_even;  // even-parity bit of data
   } vec_t;

   vec_t vecs [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sends one frame starting at the next edge and checks every cycle of it.
   task automatic frame(input logic [7:0] d, input logic [9:0] line, input logic par_even,
                        input int inj_at, input logic [7:0] inj_data, input bit inj_start,
                        input bit hold);
      logic [10:0] bits;
`ifdef UART_PARITY_EN
      bits = {1'b1, par_even ^ (PODD != 0), line[8:0]};
`else
      bits = {par_even & 1'b0, line};
`endif
      tx_start = 1'b1;
      tx_data  = d;
      tick();
      if (!hold) tx_start = 1'b0;
      for (int k = 0; k < NB * C; k++) begin
         chk($sformatf("line[%0h c%0d]", d, k), uart_txd, bits[k / C]);
         chk($sformatf("busy[%0h c%0d]", d, k), uart_tx_busy, 1'b1);
         chk($sformatf("done[%0h c%0d]", d, k), tx_done, 1'b0);
         if (k == inj_at) begin
            tx_data = inj_data;
            if (inj_start) tx_start = 1'b1;
         end else if (k == inj_at + 1 && inj_start && !hold) begin
            tx_start = 1'b0;
         end
         tick();
      end
      chk($sformatf("end_done[%0h]", d), tx_done, 1'b1);
      chk($sformatf("end_busy[%0h]", d), uart_tx_busy, 1'b0);
      chk($sformatf("end_line[%0h]", d), uart_txd, 1'b1);
      if (!hold) begin
         tick();
         chk($sformatf("post_done[%0h]", d), tx_done, 1'b0);
         chk($sformatf("post_busy[%0h]", d), uart_tx_busy, 1'b0);
         chk($sformatf("post_line[%0h]", d), uart_txd, 1'b1);
      end
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, line: 10'b1_1010_0101_0, par_even: 1'b0};
      vecs[1] = '{data: 8'h07, line: 10'b1_0000_0111_0, par_even: 1'b1};
      vecs[2] = '{data: 8'h81, line: 10'b1_1000_0001_0, par_even: 1'b0};

      reset    = 1'b1;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      tick();
      tick();
      chk("rst_line", uart_txd, 1'b1);
      chk("rst_busy", uart_tx_busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 3; i++) begin
         frame(vecs[i].data, vecs[i].line, vecs[i].par_even, -1, 8'h00, 1'b0, 1'b0);
         tick();
      end

      // Request while busy is dropped, no queued 0x3C frame afterwards
      frame(8'h55, 10'b1_0101_0101_0, 1'b0, 5, 8'h3C, 1'b1, 1'b0);
      for (int k = 0; k < 2 * C; k++) begin
         chk("no_queue_busy", uart_tx_busy, 1'b0);
         chk("no_queue_line", uart_txd, 1'b1);
         tick();
      end

      // Held start: back-to-back frames 41 cycles apart, second carries 0x00
      frame(8'hFF, 10'b1_1111_1111_0, 1'b0, 5, 8'h00, 1'b0, 1'b1);
      frame(8'h00, 10'b1_0000_0000_0, 1'b0, -1, 8'h00, 1'b0, 1'b0);
      tick();

      // Reset mid-frame at cycle 17 of a 0x81 frame
      tx_start = 1'b1;
      tx_data  = 8'h81;
      tick();
      tx_start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("abort_pre_line", uart_txd, vecs[2].line[k / C]);
         tick();
      end
      reset = 1'b1;
      tick();
      chk("abort_line", uart_txd, 1'b1);
      chk("abort_busy", uart_tx_busy, 1'b0);
      chk("abort_done", tx_done, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         chk("abort_quiet_done", tx_done, 1'b0);
         chk("abort_quiet_busy", uart_tx_busy, 1'b0);
      end
      frame(vecs[2].data, vecs[2].line, vecs[2].par_even, -1, 8'h00, 1'b0, 1'b0);

      // Reset and start on the same edge: reset wins
      reset    = 1'b1;
      tx_start = 1'b1;
      tx_data  = 8'hA5;
      tick();
      chk("rst_win_line", uart_txd, 1'b1);
      chk("rst_win_busy", uart_tx_busy, 1'b0);
      chk("rst_win_done", tx_done, 1'b0);
      reset    = 1'b0;
      tx_start = 1'b0;
      tick();
      chk("rst_win_line2", uart_txd, 1'b1);
      chk("rst_win_busy2", uart_tx_busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
